// File: rtl/pc_generator_if.sv
// Purpose : Bundles the signals between the PC stage, the hazard/decode logic
//           that steers it, and the fetcher that consumes its address.
// Modports:
//   master : drives the stall/hold and redirect inputs, observes the PC outputs
//   slave  : the PC generator itself
// Signals :
//   stall, mem_busy        hold requests (hazard unit, shared-memory data access)
//   redirect_en/_target    taken branch/jump from decode
//   current_PC, pc_plus1   fetch address and its increment (link writeback)
//   fetch_valid            current_PC is a new fetch to capture
//   redirect_pending       a redirect is buffered behind a hold
//   stall_cycles           saturating held-cycle debug counter
interface pc_generator_if #(
    parameter int PC_WIDTH = 16
);
    logic                stall;
    logic                mem_busy;
    logic                redirect_en;
    logic [PC_WIDTH-1:0] redirect_target;
    logic [PC_WIDTH-1:0] current_PC;
    logic [PC_WIDTH-1:0] pc_plus1;
    logic                fetch_valid;
    logic                redirect_pending;
    logic [15:0]         stall_cycles;

    modport master (
        output stall, mem_busy, redirect_en, redirect_target,
        input  current_PC, pc_plus1, fetch_valid, redirect_pending, stall_cycles
    );

    modport slave (
        input  stall, mem_busy, redirect_en, redirect_target,
        output current_PC, pc_plus1, fetch_valid, redirect_pending, stall_cycles
    );
endinterface

// File: rtl/pc_generator.sv
// Purpose : Program-counter stage feeding the instruction fetcher. Chooses
//           between sequential increment, decode redirect, or hold, and
//           buffers a redirect that arrives while the PC is held.
// Ports   :
//   clk     system clock, all state updates on posedge
//   rst     asynchronous active-high reset
//   pc_bus  pc_generator_if.slave (hold/redirect in, PC/status out)
//
// state | meaning
// ------+---------------------------------------------------------------
// BOOT  | first cycle after reset; PC parked at RESET_VECTOR, no fetch
// RUN   | normal sequencing: increment, redirect, or hold
// PEND  | redirect captured during a hold; waits for the hold to clear
module pc_generator #(
    parameter int                     PC_WIDTH     = 16,
    parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = '0
) (
    input  logic           clk,
    input  logic           rst,
    pc_generator_if.slave  pc_bus
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_ONE  = {{(PC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [15:0]         CNT_MAX = 16'hFFFF;
    localparam logic [15:0]         CNT_ONE = 16'h0001;

    state_t              r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] r_saved_target;
    logic [15:0]         r_stall_cycles;

    state_t              w_state_nxt;
    logic [PC_WIDTH-1:0] w_pc_nxt;
    logic [PC_WIDTH-1:0] w_saved_nxt;
    logic [15:0]         w_stall_nxt;
    logic                w_hold;

    assign w_hold = pc_bus.stall | pc_bus.mem_busy;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_BOOT;
            r_pc           <= RESET_VECTOR;
            r_saved_target <= '0;
            r_stall_cycles <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_pc           <= w_pc_nxt;
            r_saved_target <= w_saved_nxt;
            r_stall_cycles <= w_stall_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_saved_nxt = r_saved_target;
        w_stall_nxt = r_stall_cycles;

        case (r_state)
            ST_BOOT: begin
                // Hold and redirect are deliberately ignored here.
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (pc_bus.redirect_en && !w_hold) begin
                    w_pc_nxt = pc_bus.redirect_target;
                end else if (pc_bus.redirect_en) begin
                    w_saved_nxt = pc_bus.redirect_target;
                    w_state_nxt = ST_PEND;
                end else if (!w_hold) begin
                    w_pc_nxt = r_pc + PC_ONE;
                end
            end
            ST_PEND: begin
                if (w_hold) begin
                    // Newest redirect wins while still held.
                    if (pc_bus.redirect_en) begin
                        w_saved_nxt = pc_bus.redirect_target;
                    end
                end else begin
                    w_pc_nxt    = pc_bus.redirect_en ? pc_bus.redirect_target
                                                     : r_saved_target;
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase

        // One count per held edge regardless of how many hold sources are active.
        if ((r_state != ST_BOOT) && w_hold && (r_stall_cycles != CNT_MAX)) begin
            w_stall_nxt = r_stall_cycles + CNT_ONE;
        end
    end

    // Outputs
    always_comb begin
        pc_bus.current_PC       = r_pc;
        pc_bus.pc_plus1         = r_pc + PC_ONE;
        // High in the PEND release cycle too; the PC is stale then and the
        // decode-side flush discards that fetch.
        pc_bus.fetch_valid      = (r_state != ST_BOOT) && !w_hold;
        pc_bus.redirect_pending = (r_state == ST_PEND);
        pc_bus.stall_cycles     = r_stall_cycles;
    end

endmodule

// File: tb/tb_pc_generator.sv
module tb_pc_generator;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        mem_busy;
        logic        ren;
        logic [15:0] tgt;
        logic [15:0] pc;
        logic        fv;
        logic        pend;
        logic [15:0] sc;
    } vec_t;

    typedef struct {
        int          idx;
        logic [15:0] pc;
        logic        fv;
        logic        pend;
        logic [15:0] sc;
    } exp_t;

    logic clk;
    logic rst;

    pc_generator_if #(.PC_WIDTH(16)) bus ();

    pc_generator #(.PC_WIDTH(16), .RESET_VECTOR(16'h0000)) dut (
        .clk    (clk),
        .rst    (rst),
        .pc_bus (bus.slave)
    );

    vec_t vec_a[$];
    vec_t vec_b[$];
    exp_t sb[$];
    int   n_vec;
    int   n_bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic add(inout vec_t q[$], input logic r, input logic st, input logic mb,
                       input logic re, input logic [15:0] tg, input logic [15:0] pc,
                       input logic fv, input logic pd, input logic [15:0] sc);
        vec_t v;
        v.rst = r; v.stall = st; v.mem_busy = mb; v.ren = re; v.tgt = tg;
        v.pc = pc; v.fv = fv; v.pend = pd; v.sc = sc;
        q.push_back(v);
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        @(posedge clk);
        #1;
        rst                 = v.rst;
        bus.stall           = v.stall;
        bus.mem_busy        = v.mem_busy;
        bus.redirect_en     = v.ren;
        bus.redirect_target = v.tgt;
        e.idx = idx; e.pc = v.pc; e.fv = v.fv; e.pend = v.pend; e.sc = v.sc;
        sb.push_back(e);
    endtask

    // Monitor: compare whatever expectation is queued for this cycle.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            logic [15:0] exp_p1;
            e = sb.pop_front();
            exp_p1 = e.pc + 16'h0001;
            n_vec++;
            if (bus.current_PC !== e.pc) begin
                n_bad++;
                $display("FAIL vec%0d current_PC got %h exp %h", e.idx, bus.current_PC, e.pc);
            end
            if (bus.pc_plus1 !== exp_p1) begin
                n_bad++;
                $display("FAIL vec%0d pc_plus1 got %h exp %h", e.idx, bus.pc_plus1, exp_p1);
            end
            if (bus.fetch_valid !== e.fv) begin
                n_bad++;
                $display("FAIL vec%0d fetch_valid got %b exp %b", e.idx, bus.fetch_valid, e.fv);
            end
            if (bus.redirect_pending !== e.pend) begin
                n_bad++;
                $display("FAIL vec%0d redirect_pending got %b exp %b", e.idx, bus.redirect_pending, e.pend);
            end
            if (bus.stall_cycles !== e.sc) begin
                n_bad++;
                $display("FAIL vec%0d stall_cycles got %h exp %h", e.idx, bus.stall_cycles, e.sc);
            end
        end
    end

    initial begin
        int wait_cnt;
        n_vec = 0;
        n_bad = 0;
        rst                 = 1'b1;
        bus.stall           = 1'b0;
        bus.mem_busy        = 1'b0;
        bus.redirect_en     = 1'b0;
        bus.redirect_target = 16'h0000;

        //            rst st mb re tgt       pc        fv pd sc
        // reset, BOOT ignores hold and redirect, free run
        add(vec_a, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'd0);
        add(vec_a, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'd0);
        add(vec_a, 0, 1, 0, 1, 16'h1234, 16'h0000, 0, 0, 16'd0);
        add(vec_a, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'd0);
        add(vec_a, 0, 0, 0, 0, 16'h0000, 16'h0001, 1, 0, 16'd0);
        add(vec_a, 0, 0, 0, 0, 16'h0000, 16'h0002, 1, 0, 16'd0);
        // wrap-around
        add(vec_a, 0, 0, 0, 1, 16'hFFFE, 16'h0003, 1, 0, 16'd0);
        add(vec_a, 0, 0, 0, 0, 16'h0000, 16'hFFFE, 1, 0, 16'd0);
        add(vec_a, 0, 0, 0, 0, 16'h0000, 16'hFFFF, 1, 0, 16'd0);
        add(vec_a, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'd0);
        // redirect without stall
        add(vec_a, 0, 0, 0, 1, 16'h0010, 16'h0001, 1, 0, 16'd0);
        add(vec_a, 0, 0, 0, 1, 16'h0040, 16'h0010, 1, 0, 16'd0);
        add(vec_a, 0, 0, 0, 0, 16'h0000, 16'h0040, 1, 0, 16'd0);
        add(vec_a, 0, 0, 0, 1, 16'h0020, 16'h0041, 1, 0, 16'd0);
        // redirect during 3-cycle stall
        add(vec_a, 0, 1, 0, 1, 16'h0080, 16'h0020, 0, 0, 16'd0);
        add(vec_a, 0, 1, 0, 0, 16'h0000, 16'h0020, 0, 1, 16'd1);
        add(vec_a, 0, 1, 0, 0, 16'h0000, 16'h0020, 0, 1, 16'd2);
        add(vec_a, 0, 0, 0, 0, 16'h0000, 16'h0020, 1, 1, 16'd3);
        add(vec_a, 0, 0, 0, 0, 16'h0000, 16'h0080, 1, 0, 16'd3);
        // overwrite with mixed hold sources
        add(vec_a, 0, 0, 1, 1, 16'h0100, 16'h0081, 0, 0, 16'd3);
        add(vec_a, 0, 1, 1, 1, 16'h0200, 16'h0081, 0, 1, 16'd4);
        add(vec_a, 0, 0, 0, 0, 16'h0000, 16'h0081, 1, 1, 16'd5);
        add(vec_a, 0, 0, 0, 0, 16'h0000, 16'h0200, 1, 0, 16'd5);
        // redirect present in the release cycle beats the buffered one
        add(vec_a, 0, 0, 1, 1, 16'h0300, 16'h0201, 0, 0, 16'd5);
        add(vec_a, 0, 0, 0, 1, 16'h0400, 16'h0201, 1, 1, 16'd6);
        // plain hold in RUN
        add(vec_a, 0, 1, 0, 0, 16'h0000, 16'h0400, 0, 0, 16'd6);
        add(vec_a, 0, 0, 0, 0, 16'h0000, 16'h0400, 1, 0, 16'd7);
        // enter PEND with 0500 buffered
        add(vec_a, 0, 1, 0, 1, 16'h0500, 16'h0401, 0, 0, 16'd7);
        add(vec_a, 0, 1, 0, 0, 16'h0000, 16'h0401, 0, 1, 16'd8);

        // after async reset: 0500 must never appear
        add(vec_b, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'd0);
        add(vec_b, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'd0);
        add(vec_b, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'd0);
        add(vec_b, 0, 0, 0, 0, 16'h0000, 16'h0001, 1, 0, 16'd0);
        add(vec_b, 0, 0, 0, 0, 16'h0000, 16'h0002, 1, 0, 16'd0);

        foreach (vec_a[i]) apply(vec_a[i], i);

        // Mid-cycle asynchronous reset while a redirect is pending.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (bus.current_PC !== 16'h0000) begin
            n_bad++;
            $display("FAIL async_rst current_PC got %h exp %h", bus.current_PC, 16'h0000);
        end
        if (bus.redirect_pending !== 1'b0) begin
            n_bad++;
            $display("FAIL async_rst redirect_pending got %b exp %b", bus.redirect_pending, 1'b0);
        end
        if (bus.stall_cycles !== 16'h0000) begin
            n_bad++;
            $display("FAIL async_rst stall_cycles got %h exp %h", bus.stall_cycles, 16'h0000);
        end
        bus.stall       = 1'b0;
        bus.redirect_en = 1'b0;

        foreach (vec_b[i]) apply(vec_b[i], 100 + i);

        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain scoreboard left %0d exp %0d", sb.size(), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
